// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory bus interface:
// bus FSM encoding, write-buffer entry layout and the default fault data.
package dmem_pkg;

   typedef enum logic [1:0] {
      B_IDLE  = 2'd0,
      B_WRITE = 2'd1,
      B_READ  = 2'd2
   } bus_state_t;

   localparam logic [31:0] FAULT_DATA_DEF = 32'hDEADBEEF;
   localparam int          WBUF_ENTRY_W   = 66;

   typedef struct packed {
      logic [29:0] waddr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } wbuf_entry_t;

endpackage

// File: rtl/dmem_bus_if_if.sv
// External single-outstanding req/ack data bus; the memory interface is the
// master, the memory or bus fabric is the slave.
interface dmem_bus_if_if;
   logic        bus_req;
   logic        bus_we;
   logic [29:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic [31:0] bus_rdata;
   logic        bus_ack;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
      input  bus_rdata, bus_ack
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
      output bus_rdata, bus_ack
   );
endinterface

// File: rtl/dmem_bus_if_wbuf_fifo.sv
// Store write buffer: synchronous FIFO with a first-word-fall-through head;
// a push into a full FIFO is accepted when a pop happens in the same cycle.
module wbuf_fifo #(
   parameter int WIDTH = 66,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   always_comb begin
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
   end

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];

   // Storage array; pointers alone define which words are valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointer and occupancy tracking.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dmem_bus_if.sv
// M-stage data-memory interface: posts stores into a write buffer, orders
// loads behind them and runs a single-outstanding req/ack bus with timeout.
module dmem_bus_if
   import dmem_pkg::*;
#(
   parameter int          WBUF_DEPTH = 2,
   parameter int          TIMEOUT    = 255,
   parameter logic [31:0] FAULT_DATA = FAULT_DATA_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          mem_re_M,
   input  logic          mem_we_M,
   input  logic [31:0]   addr_M,
   input  logic [31:0]   write_data_M,
   input  logic [3:0]    byte_en_M,
   input  logic          advance_M,
   input  logic          flush_M,
   output logic [31:0]   read_data_M,
   output logic          data_mem_ack,
   dmem_bus_if_if.master bus,
   output logic          bus_fault,
   output logic          wbuf_empty
);
   localparam int         CW          = $clog2(WBUF_DEPTH) + 1;
   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   bus_state_t  state;
   logic        cpu_done, rd_pend, rd_kill;
   logic [29:0] rd_addr;
   logic [7:0]  wait_cnt;
   logic        req, we;
   logic [29:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  be_q;

   wbuf_entry_t push_entry, head;
   logic        fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   logic        pop, store_go, load_go, bus_done, timed_out, rd_done;
   logic        next_write, next_fifo_empty;
   logic        addr_lsb_unused;

   assign addr_lsb_unused = ^addr_M[1:0];

   assign bus.bus_req   = req;
   assign bus.bus_we    = we;
   assign bus.bus_addr  = addr_q;
   assign bus.bus_wdata = wdata_q;
   assign bus.bus_be    = be_q;
   assign data_mem_ack  = cpu_done;

   always_comb begin
      push_entry      = '{waddr: addr_M[31:2], wdata: write_data_M, be: byte_en_M};
      pop             = (state == B_IDLE) && !fifo_empty;
      store_go        = mem_we_M && !cpu_done && !flush_M && (!fifo_full || pop);
      load_go         = mem_re_M && !mem_we_M && !cpu_done && !flush_M && !rd_pend;
      timed_out       = (state != B_IDLE) && !bus.bus_ack && (wait_cnt == TIMEOUT_CNT);
      bus_done        = (state != B_IDLE) && (bus.bus_ack || (wait_cnt == TIMEOUT_CNT));
      rd_done         = (state == B_READ) && bus_done;
      next_write      = pop || ((state == B_WRITE) && !bus_done);
      // Occupancy after this edge is zero only with no push and nothing left behind the pop.
      next_fifo_empty = !store_go &&
                        ((fifo_count == CW'(0)) || ((fifo_count == CW'(1)) && pop));
   end

   wbuf_fifo #(
      .WIDTH (WBUF_ENTRY_W),
      .DEPTH (WBUF_DEPTH)
   ) u_wbuf (
      .clk   (clk),
      .reset (reset),
      .push  (store_go),
      .pop   (pop),
      .din   (push_entry),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Bus FSM: drains buffered stores first, then the pending load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= B_IDLE;
         req        <= 1'b0;
         we         <= 1'b0;
         addr_q     <= 30'd0;
         wdata_q    <= 32'd0;
         be_q       <= 4'd0;
         wait_cnt   <= 8'd0;
         bus_fault  <= 1'b0;
         wbuf_empty <= 1'b1;
      end else begin
         bus_fault  <= 1'b0;
         wbuf_empty <= next_fifo_empty && !next_write;
         case (state)
            B_IDLE: begin
               if (!fifo_empty) begin
                  addr_q   <= head.waddr;
                  wdata_q  <= head.wdata;
                  be_q     <= head.be;
                  req      <= 1'b1;
                  we       <= 1'b1;
                  wait_cnt <= 8'd0;
                  state    <= B_WRITE;
               end else if (rd_pend) begin
                  addr_q   <= rd_addr;
                  wdata_q  <= 32'd0;
                  be_q     <= 4'hF;
                  req      <= 1'b1;
                  we       <= 1'b0;
                  wait_cnt <= 8'd0;
                  state    <= B_READ;
               end else begin
                  state    <= B_IDLE;
               end
            end
            B_WRITE, B_READ: begin
               if (bus_done) begin
                  req       <= 1'b0;
                  bus_fault <= timed_out;
                  state     <= B_IDLE;
               end else begin
                  wait_cnt  <= wait_cnt + 8'd1;
               end
            end
            default: begin
               req   <= 1'b0;
               state <= B_IDLE;
            end
         endcase
      end
   end

   // Pipeline-side handshake: store posting, load tracking and flush discard.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cpu_done    <= 1'b0;
         rd_pend     <= 1'b0;
         rd_kill     <= 1'b0;
         rd_addr     <= 30'd0;
         read_data_M <= 32'd0;
      end else begin
         if (rd_done)      rd_pend <= 1'b0;
         else if (load_go) rd_pend <= 1'b1;

         if (load_go) rd_addr <= addr_M[31:2];

         if (rd_done)                 rd_kill <= 1'b0;
         else if (flush_M && rd_pend) rd_kill <= 1'b1;

         if (rd_done && !rd_kill && !flush_M) begin
            read_data_M <= bus.bus_ack ? bus.bus_rdata : FAULT_DATA;
         end

         if (flush_M)                          cpu_done <= 1'b0;
         else if (cpu_done && advance_M)       cpu_done <= 1'b0;
         else if (store_go)                    cpu_done <= 1'b1;
         else if (rd_done && !rd_kill)         cpu_done <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dmem_bus_if.sv
// Directed bench for dmem_bus_if: table-driven loads, then hand-written
// sequences for buffer-full stalls, ordering, timeout, flush and reset.
module tb_dmem_bus_if;
   logic        clk = 1'b0;
   logic        reset;
   logic        mem_re_M, mem_we_M, advance_M, flush_M;
   logic [31:0] addr_M, write_data_M;
   logic [3:0]  byte_en_M;
   logic [31:0] read_data_M;
   logic        data_mem_ack, bus_fault, wbuf_empty;

   dmem_bus_if_if bus_i ();

   dmem_bus_if dut (
      .clk          (clk),
      .reset        (reset),
      .mem_re_M     (mem_re_M),
      .mem_we_M     (mem_we_M),
      .addr_M       (addr_M),
      .write_data_M (write_data_M),
      .byte_en_M    (byte_en_M),
      .advance_M    (advance_M),
      .flush_M      (flush_M),
      .read_data_M  (read_data_M),
      .data_mem_ack (data_mem_ack),
      .bus          (bus_i),
      .bus_fault    (bus_fault),
      .wbuf_empty   (wbuf_empty)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] rdata;
      int          delay;
      logic [29:0] exp_baddr;
   } ld_vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
      logic [29:0] exp_baddr;
   } st_vec_t;

   ld_vec_t ld_tab[4];
   st_vec_t st_tab[4];
   int n_cmp  = 0;
   int n_fail = 0;
   int n_wait;
   logic [31:0] last_rd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic retire();
      advance_M = 1'b1;
      tick();
      advance_M = 1'b0;
      mem_re_M  = 1'b0;
      mem_we_M  = 1'b0;
   endtask

   task automatic wait_req(input string tag);
      for (int i = 0; i < 20 && bus_i.bus_req !== 1'b1; i++) tick();
      check({tag, "_req"}, {31'd0, bus_i.bus_req}, 32'd1);
   endtask

   task automatic store_issue(input st_vec_t v);
      mem_we_M     = 1'b1;
      addr_M       = v.addr;
      write_data_M = v.data;
      byte_en_M    = v.be;
   endtask

   task automatic bus_write_expect(input st_vec_t v, input string tag);
      wait_req(tag);
      check({tag, "_we"},    {31'd0, bus_i.bus_we}, 32'd1);
      check({tag, "_addr"},  {2'd0, bus_i.bus_addr}, {2'd0, v.exp_baddr});
      check({tag, "_wdata"}, bus_i.bus_wdata, v.data);
      check({tag, "_be"},    {28'd0, bus_i.bus_be}, {28'd0, v.be});
      bus_i.bus_ack = 1'b1;
      tick();
      bus_i.bus_ack = 1'b0;
      check({tag, "_req_drop"}, {31'd0, bus_i.bus_req}, 32'd0);
   endtask

   task automatic do_load(input ld_vec_t v, input string tag);
      mem_re_M = 1'b1;
      addr_M   = v.addr;
      wait_req(tag);
      check({tag, "_we"},   {31'd0, bus_i.bus_we}, 32'd0);
      check({tag, "_addr"}, {2'd0, bus_i.bus_addr}, {2'd0, v.exp_baddr});
      check({tag, "_be"},   {28'd0, bus_i.bus_be}, 32'h0000000F);
      repeat (v.delay) tick();
      check({tag, "_ack_early"}, {31'd0, data_mem_ack}, 32'd0);
      bus_i.bus_ack   = 1'b1;
      bus_i.bus_rdata = v.rdata;
      tick();
      bus_i.bus_ack   = 1'b0;
      check({tag, "_ack"},  {31'd0, data_mem_ack}, 32'd1);
      check({tag, "_data"}, read_data_M, v.rdata);
      tick();
      check({tag, "_ack_hold"}, {31'd0, data_mem_ack}, 32'd1);
      retire();
      check({tag, "_ack_clr"},   {31'd0, data_mem_ack}, 32'd0);
      check({tag, "_data_hold"}, read_data_M, v.rdata);
      last_rd = v.rdata;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ld_tab[0] = '{32'h00001004, 32'h12345678, 3, 30'h00000401};
      ld_tab[1] = '{32'hFFFFFFFC, 32'hA5A5A5A5, 0, 30'h3FFFFFFF};
      ld_tab[2] = '{32'h00000003, 32'h00000000, 1, 30'h00000000};
      ld_tab[3] = '{32'h80000010, 32'hFFFFFFFF, 5, 30'h20000004};
      st_tab[0] = '{32'h00000200, 32'h11111111, 4'hF,    30'h00000080};
      st_tab[1] = '{32'h00000207, 32'h22000000, 4'b1000, 30'h00000081};
      st_tab[2] = '{32'h0000FFF0, 32'h00330000, 4'b0100, 30'h00003FFC};
      st_tab[3] = '{32'h7FFFFFFE, 32'h44440000, 4'b1100, 30'h1FFFFFFF};

      reset = 1'b1;
      mem_re_M = 1'b0; mem_we_M = 1'b0; advance_M = 1'b0; flush_M = 1'b0;
      addr_M = 32'd0; write_data_M = 32'd0; byte_en_M = 4'd0;
      bus_i.bus_ack = 1'b0; bus_i.bus_rdata = 32'd0;
      tick(); tick();
      check("rst_rdata",  read_data_M, 32'd0);
      check("rst_ack",    {31'd0, data_mem_ack}, 32'd0);
      check("rst_req",    {31'd0, bus_i.bus_req}, 32'd0);
      check("rst_we",     {31'd0, bus_i.bus_we}, 32'd0);
      check("rst_addr",   {2'd0, bus_i.bus_addr}, 32'd0);
      check("rst_wdata",  bus_i.bus_wdata, 32'd0);
      check("rst_be",     {28'd0, bus_i.bus_be}, 32'd0);
      check("rst_fault",  {31'd0, bus_fault}, 32'd0);
      check("rst_wbempty",{31'd0, wbuf_empty}, 32'd1);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 4; i++) begin
         do_load(ld_tab[i], $sformatf("ld%0d", i));
      end

      // Stores back to back: the first is already on the bus, so two more
      // fill the buffer and the fourth waits for the first bus_ack.
      for (int i = 0; i < 3; i++) begin
         store_issue(st_tab[i]);
         tick();
         check($sformatf("st%0d_ack", i), {31'd0, data_mem_ack}, 32'd1);
         check($sformatf("st%0d_wbempty", i), {31'd0, wbuf_empty}, 32'd0);
         retire();
      end
      check("full_req",  {31'd0, bus_i.bus_req}, 32'd1);
      check("full_addr", {2'd0, bus_i.bus_addr}, {2'd0, st_tab[0].exp_baddr});
      store_issue(st_tab[3]);
      repeat (4) tick();
      check("st3_stall", {31'd0, data_mem_ack}, 32'd0);
      bus_write_expect(st_tab[0], "drain0");
      check("st3_stall_ack_cycle", {31'd0, data_mem_ack}, 32'd0);
      tick();
      check("st3_ack", {31'd0, data_mem_ack}, 32'd1);
      retire();
      for (int i = 1; i < 4; i++) begin
         bus_write_expect(st_tab[i], $sformatf("drain%0d", i));
      end
      tick();
      check("drain_wbempty", {31'd0, wbuf_empty}, 32'd1);

      // Load behind a buffered store to the same word.
      store_issue('{32'h00000100, 32'hAAAAAAAA, 4'b0001, 30'h00000040});
      tick();
      retire();
      mem_re_M = 1'b1;
      addr_M   = 32'h00000100;
      bus_write_expect('{32'h00000100, 32'hAAAAAAAA, 4'b0001, 30'h00000040}, "order_wr");
      wait_req("order_rd");
      check("order_rd_we",      {31'd0, bus_i.bus_we}, 32'd0);
      check("order_rd_addr",    {2'd0, bus_i.bus_addr}, 32'h00000040);
      check("order_rd_wbempty", {31'd0, wbuf_empty}, 32'd1);
      bus_i.bus_ack = 1'b1; bus_i.bus_rdata = 32'h000000AA;
      tick();
      bus_i.bus_ack = 1'b0;
      check("order_rd_data", read_data_M, 32'h000000AA);
      retire();

      // Load timeout.
      mem_re_M = 1'b1;
      addr_M   = 32'h00002000;
      wait_req("to");
      n_wait = 0;
      while (bus_i.bus_req === 1'b1 && n_wait < 300) begin
         tick();
         n_wait++;
      end
      check("to_cycles", n_wait, 32'd256);
      check("to_fault",  {31'd0, bus_fault}, 32'd1);
      check("to_ack",    {31'd0, data_mem_ack}, 32'd1);
      check("to_data",   read_data_M, 32'hDEADBEEF);
      tick();
      check("to_fault_pulse", {31'd0, bus_fault}, 32'd0);
      retire();
      last_rd = 32'hDEADBEEF;

      // Flushed load: the bus read completes but its data is dropped.
      mem_re_M = 1'b1;
      addr_M   = 32'h00003000;
      wait_req("fl");
      flush_M  = 1'b1;
      mem_re_M = 1'b0;
      tick();
      flush_M  = 1'b0;
      repeat (2) tick();
      bus_i.bus_ack = 1'b1; bus_i.bus_rdata = 32'hBAD0BAD0;
      tick();
      bus_i.bus_ack = 1'b0;
      check("fl_req_drop", {31'd0, bus_i.bus_req}, 32'd0);
      check("fl_ack",      {31'd0, data_mem_ack}, 32'd0);
      check("fl_data",     read_data_M, last_rd);
      tick();
      check("fl_ack_later", {31'd0, data_mem_ack}, 32'd0);
      do_load('{32'h00003004, 32'hCAFEF00D, 2, 30'h00000C01}, "post_fl");

      // Reset in the middle of a write with two entries queued behind it.
      for (int i = 0; i < 3; i++) begin
         store_issue(st_tab[i]);
         tick();
         retire();
      end
      check("rw_req_before", {31'd0, bus_i.bus_req}, 32'd1);
      reset = 1'b1;
      #1;
      check("rw_req_async", {31'd0, bus_i.bus_req}, 32'd0);
      check("rw_wbempty",   {31'd0, wbuf_empty}, 32'd1);
      check("rw_ack",       {31'd0, data_mem_ack}, 32'd0);
      tick();
      reset = 1'b0;
      bus_i.bus_ack = 1'b1;
      tick();
      bus_i.bus_ack = 1'b0;
      check("rw_late_ack_req", {31'd0, bus_i.bus_req}, 32'd0);
      repeat (3) tick();
      check("rw_idle_req",     {31'd0, bus_i.bus_req}, 32'd0);
      check("rw_idle_wbempty", {31'd0, wbuf_empty}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
